// File: rtl/mem_stage.sv
// RV32I memory stage: registers the EX/MEM bundle, runs byte/half/word accesses over a
// req/ready data port with a bus timeout, resolves branches and drives the MEM/WB bundle.
module mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [4:0]  crt_mem_in,
  input  logic        mem_unsigned_in,
  input  logic [1:0]  crt_wb_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] dato_b_in,
  input  logic [31:0] pc_target_in,
  input  logic        zero_in,
  input  logic [4:0]  inst_in,
  output logic        stall_out,
  output logic        pc_src_out,
  output logic [31:0] pc_target_out,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        valid_out,
  output logic [31:0] wb_data_out,
  output logic [4:0]  rd_out,
  output logic [1:0]  crt_wb_out,
  output logic [1:0]  exc_out,
  output logic        state_dbg_o
);
  // Handshake: an access completes on a rising edge where dmem_req=1 and dmem_ready=1;
  // req, we, addr, be and wdata stay constant from the first ACCESS cycle until then.
  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

  localparam int CW = $clog2(TIMEOUT) + 1;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          valid_q, pc_src_q, we_q;
  logic [31:0]   pc_target_q, addr_q, wdata_q, wb_data_q, alu_q;
  logic [3:0]    be_q;
  logic [4:0]    rd_out_q, rd_pend_q;
  logic [1:0]    crt_wb_q, wb_pend_q, exc_q, off_q, size_q;
  logic          uns_q;

  logic          is_wr, is_rd, is_mem;
  logic [1:0]    size, off, exc_d;
  logic [3:0]    be_d;
  logic [31:0]   wdata_d, shifted, load_d;

  assign is_wr  = crt_mem_in[1];
  assign is_rd  = crt_mem_in[0] & ~crt_mem_in[1];
  assign is_mem = is_wr | is_rd;
  assign size   = crt_mem_in[4:3];
  assign off    = alu_result_in[1:0];

  always_comb begin
    exc_d   = 2'b00;
    be_d    = 4'hF;
    wdata_d = dato_b_in;
    if (is_mem) begin
      if (size == 2'b11) exc_d = 2'b11;
      else if ((size == 2'b01 && off[0]) || (size == 2'b10 && off != 2'b00)) exc_d = 2'b01;
    end
    case (size)
      2'b00: begin
        be_d    = 4'b0001 << off;
        wdata_d = {4{dato_b_in[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << off;
        wdata_d = {2{dato_b_in[15:0]}};
      end
      default: ;
    endcase
  end

  // Load lane is selected with the offset captured at accept time.
  always_comb begin
    shifted = dmem_rdata >> {off_q, 3'b000};
    load_d  = shifted;
    case (size_q)
      2'b00:   load_d = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_d = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      valid_q     <= 1'b0;
      pc_src_q    <= 1'b0;
      pc_target_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      wb_data_q   <= '0;
      rd_out_q    <= '0;
      crt_wb_q    <= '0;
      exc_q       <= '0;
      alu_q       <= '0;
      rd_pend_q   <= '0;
      wb_pend_q   <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
    end else begin
      valid_q  <= 1'b0;
      pc_src_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_in) begin
            pc_src_q    <= crt_mem_in[2] & zero_in;
            pc_target_q <= pc_target_in;
            alu_q       <= alu_result_in;
            rd_pend_q   <= inst_in;
            wb_pend_q   <= is_wr ? 2'b00 : crt_wb_in;
            off_q       <= off;
            size_q      <= size;
            uns_q       <= mem_unsigned_in;
            if (is_mem && exc_d == 2'b00) begin
              state_q <= ACCESS;
              cnt_q   <= '0;
              addr_q  <= {alu_result_in[31:2], 2'b00};
              we_q    <= is_wr;
              be_q    <= be_d;
              wdata_q <= wdata_d;
            end else begin
              valid_q   <= 1'b1;
              wb_data_q <= alu_result_in;
              rd_out_q  <= inst_in;
              crt_wb_q  <= (exc_d != 2'b00 || is_wr) ? 2'b00 : crt_wb_in;
              exc_q     <= exc_d;
            end
          end
        end
        ACCESS: begin
          if (dmem_ready) begin
            state_q   <= IDLE;
            valid_q   <= 1'b1;
            wb_data_q <= (wb_pend_q[1] && !we_q) ? load_d : alu_q;
            rd_out_q  <= rd_pend_q;
            crt_wb_q  <= wb_pend_q;
            exc_q     <= 2'b00;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            state_q   <= IDLE;
            valid_q   <= 1'b1;
            wb_data_q <= alu_q;
            rd_out_q  <= rd_pend_q;
            crt_wb_q  <= 2'b00;
            exc_q     <= 2'b10;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall_out     = (state_q == ACCESS);
  assign dmem_req      = (state_q == ACCESS);
  assign state_dbg_o   = state_q;
  assign pc_src_out    = pc_src_q;
  assign pc_target_out = pc_target_q;
  assign dmem_we       = we_q;
  assign dmem_addr     = addr_q;
  assign dmem_wdata    = wdata_q;
  assign dmem_be       = be_q;
  assign valid_out     = valid_q;
  assign wb_data_out   = wb_data_q;
  assign rd_out        = rd_out_q;
  assign crt_wb_out    = crt_wb_q;
  assign exc_out       = exc_q;
endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed cases then random operations, each compared against a
// behavioural model of loads, stores, exceptions and branches.
module tb_mem_stage;
  localparam int TO = 4;

  logic        clk, rst, valid_in, mem_unsigned_in, zero_in, dmem_ready;
  logic [4:0]  crt_mem_in, inst_in;
  logic [1:0]  crt_wb_in;
  logic [31:0] alu_result_in, dato_b_in, pc_target_in, dmem_rdata;
  logic        stall_out, pc_src_out, dmem_req, dmem_we, valid_out, state_dbg_o;
  logic [31:0] pc_target_out, dmem_addr, dmem_wdata, wb_data_out;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_out;
  logic [1:0]  crt_wb_out, exc_out;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .crt_mem_in(crt_mem_in),
    .mem_unsigned_in(mem_unsigned_in), .crt_wb_in(crt_wb_in), .alu_result_in(alu_result_in),
    .dato_b_in(dato_b_in), .pc_target_in(pc_target_in), .zero_in(zero_in), .inst_in(inst_in),
    .stall_out(stall_out), .pc_src_out(pc_src_out), .pc_target_out(pc_target_out),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .valid_out(valid_out), .wb_data_out(wb_data_out), .rd_out(rd_out),
    .crt_wb_out(crt_wb_out), .exc_out(exc_out), .state_dbg_o(state_dbg_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [1:0] off,
                                             input int nb, input logic uns);
    longint v;
    longint full;
    full = longint'(1) << (8 * nb);
    v = (longint'(rdata) >> (8 * off)) % full;
    if (!uns && v >= full / 2) v = v - full;
    return 32'(v);
  endfunction

  // delay = ACCESS cycle on which ready arrives (1 = first); 0 or > TO means never.
  task automatic run_op(input logic [4:0] cm, input logic un, input logic [1:0] cw,
                        input logic [31:0] alu, input logic [31:0] b, input logic [31:0] pt,
                        input logic z, input logic [4:0] rd, input logic [31:0] rdata,
                        input int delay);
    logic wr, rdop, is_mem, tmo, br;
    logic [1:0] exc_e, cw_e;
    logic [3:0] be_e;
    logic [31:0] wd_e, wb_e;
    int nb;
    logic done;
    wr     = cm[1];
    rdop   = cm[0] & ~cm[1];
    is_mem = cm[0] | cm[1];
    br     = cm[2] & z;
    nb     = (cm[4:3] == 2'd0) ? 1 : (cm[4:3] == 2'd1) ? 2 : 4;
    exc_e  = 2'b00;
    if (is_mem) begin
      if (cm[4:3] == 2'b11) exc_e = 2'b11;
      else if (alu % 32'(nb) != 0) exc_e = 2'b01;
    end
    be_e = 4'(((1 << nb) - 1) << alu[1:0]);
    wd_e = (nb == 1) ? (b & 32'hFF) * 32'h0101_0101 :
           (nb == 2) ? (b & 32'hFFFF) * 32'h0001_0001 : b;
    tmo  = is_mem && exc_e == 2'b00 && (delay == 0 || delay > TO);
    cw_e = (exc_e != 2'b00 || wr || tmo) ? 2'b00 : cw;
    wb_e = (is_mem && exc_e == 2'b00 && !tmo && rdop && cw[1]) ?
           model_load(rdata, alu[1:0], nb, un) : alu;
    if (tmo) exc_e = 2'b10;
    exp_q.push_back(wb_e);

    @(negedge clk);
    valid_in = 1'b1; crt_mem_in = cm; mem_unsigned_in = un; crt_wb_in = cw;
    alu_result_in = alu; dato_b_in = b; pc_target_in = pt; zero_in = z; inst_in = rd;
    @(negedge clk);
    valid_in = 1'b0;
    chk("pc_src", 32'(pc_src_out), 32'(br));
    if (br) chk("pc_target", pc_target_out, pt);
    if (is_mem && exc_e != 2'b11 && exc_e != 2'b01) begin
      done = 1'b0;
      for (int k = 1; k <= TO && !done; k++) begin
        chk("req", 32'(dmem_req), 32'd1);
        chk("stall", 32'(stall_out), 32'd1);
        chk("addr", dmem_addr, {alu[31:2], 2'b00});
        chk("we", 32'(dmem_we), 32'(wr));
        chk("be", 32'(dmem_be), 32'(be_e));
        if (wr) chk("wdata", dmem_wdata, wd_e);
        chk("no_valid", 32'(valid_out), 32'd0);
        valid_in = 1'($urandom_range(0, 1));
        alu_result_in = $urandom();
        dmem_ready = (k == delay);
        dmem_rdata = (k == delay) ? rdata : $urandom();
        @(negedge clk);
        dmem_ready = 1'b0;
        valid_in = 1'b0;
        if (k == delay) done = 1'b1;
      end
    end
    chk("valid", 32'(valid_out), 32'd1);
    chk("wb_data", wb_data_out, exp_q.pop_front());
    chk("rd", 32'(rd_out), 32'(rd));
    chk("crt_wb", 32'(crt_wb_out), 32'(cw_e));
    chk("exc", 32'(exc_out), 32'(exc_e));
    chk("req_idle", 32'(dmem_req), 32'd0);
    chk("stall_idle", 32'(stall_out), 32'd0);
    @(negedge clk);
    chk("valid_pulse", 32'(valid_out), 32'd0);
    chk("pc_src_pulse", 32'(pc_src_out), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_pc_src"}, 32'(pc_src_out), 32'd0);
    chk({tag, "_pc_target"}, pc_target_out, 32'd0);
    chk({tag, "_req"}, 32'(dmem_req), 32'd0);
    chk({tag, "_we"}, 32'(dmem_we), 32'd0);
    chk({tag, "_addr"}, dmem_addr, 32'd0);
    chk({tag, "_wdata"}, dmem_wdata, 32'd0);
    chk({tag, "_be"}, 32'(dmem_be), 32'd0);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_wb_data"}, wb_data_out, 32'd0);
    chk({tag, "_rd"}, 32'(rd_out), 32'd0);
    chk({tag, "_crt_wb"}, 32'(crt_wb_out), 32'd0);
    chk({tag, "_exc"}, 32'(exc_out), 32'd0);
  endtask

  initial begin
    rst = 1'b1; valid_in = 1'b0; crt_mem_in = '0; mem_unsigned_in = 1'b0; crt_wb_in = '0;
    alu_result_in = '0; dato_b_in = '0; pc_target_in = '0; zero_in = 1'b0; inst_in = '0;
    dmem_rdata = '0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;

    run_op(5'b00000, 1'b0, 2'b01, 32'h1234, 32'h0, 32'h0, 1'b0, 5'd3, 32'h0, 0);
    run_op(5'b00001, 1'b0, 2'b11, 32'h103, 32'h0, 32'h0, 1'b0, 5'd4, 32'h80FF_FFFF, 3);
    run_op(5'b01010, 1'b0, 2'b00, 32'h202, 32'hAAAA_BEEF, 32'h0, 1'b0, 5'd5, 32'h0, 1);
    run_op(5'b10001, 1'b0, 2'b11, 32'h101, 32'h0, 32'h0, 1'b0, 5'd6, 32'h0, 1);
    run_op(5'b11001, 1'b0, 2'b11, 32'h100, 32'h0, 32'h0, 1'b0, 5'd7, 32'h0, 1);
    run_op(5'b10001, 1'b0, 2'b11, 32'h300, 32'h0, 32'h0, 1'b0, 5'd8, 32'h0, 0);
    run_op(5'b00100, 1'b0, 2'b00, 32'h0, 32'h0, 32'h40, 1'b1, 5'd0, 32'h0, 0);
    run_op(5'b00100, 1'b0, 2'b00, 32'h0, 32'h0, 32'h80, 1'b0, 5'd0, 32'h0, 0);
    run_op(5'b10011, 1'b0, 2'b11, 32'h400, 32'h1122_3344, 32'h0, 1'b0, 5'd9, 32'h0, 2);
    run_op(5'b01001, 1'b1, 2'b11, 32'h2, 32'h0, 32'h0, 1'b0, 5'd10, 32'h8001_0000, 1);
    run_op(5'b00001, 1'b1, 2'b11, 32'h501, 32'h0, 32'h0, 1'b0, 5'd11, 32'h1234_F678, 4);

    // Ready arriving while idle must not produce a bundle.
    @(negedge clk);
    dmem_ready = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    dmem_ready = 1'b0;
    chk("idle_ready_valid", 32'(valid_out), 32'd0);
    chk("idle_ready_req", 32'(dmem_req), 32'd0);

    // Reset in the middle of an access drops it.
    valid_in = 1'b1; crt_mem_in = 5'b10010; alu_result_in = 32'h600; dato_b_in = 32'h55;
    crt_wb_in = 2'b00; inst_in = 5'd1; zero_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b0;
    chk("mid_req", 32'(dmem_req), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_all_zero("mid_reset");
    rst = 1'b0;

    for (int i = 0; i < 60; i++) begin
      logic [4:0] cm;
      cm = 5'($urandom());
      if ($urandom_range(0, 7) != 0 && cm[4:3] == 2'b11) cm[4:3] = 2'($urandom_range(0, 2));
      run_op(cm, 1'($urandom()), 2'($urandom()), $urandom(), $urandom(), $urandom(),
             1'($urandom()), 5'($urandom()), $urandom(), $urandom_range(0, TO + 1));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
